// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   lsu_state_t : FSM state encoding (ERR is reachable only when the
//                 MISALIGN_TRAP_EN macro is defined)
//   F3_*        : RV32I load/store funct3 codes
//   f3_is_byte / f3_is_half : size decode; every other code is a word access
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LD_RD  = 3'd1,
        LD_CAP = 3'd2,
        ST_WR  = 3'd3,
        RMW_RD = 3'd4,
        RMW_WR = 3'd5,
        ERR    = 3'd6
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte access: B or BU.
    function automatic logic f3_is_byte(input logic [2:0] f3);
        return (f3[1:0] == 2'b00);
    endfunction

    // Half access: H or HU. Codes 011/110/111 fall through to word.
    function automatic logic f3_is_half(input logic [2:0] f3);
        return (f3[1:0] == 2'b01);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane handling for the load/store unit.
// Ports:
//   rdata_i     in  32  word read from memory
//   wdata_i     in  32  store data (low byte/half used for B/H)
//   lane_i      in   2  byte lane = addr[1:0], little-endian
//   funct3_i    in   3  access type
//   rdata_ext_o out 32  selected lane, sign/zero-extended (load_extract)
//   merged_o    out 32  rdata_i with the addressed lane(s) replaced (store_merge)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] rdata_ext_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Load extract: pick byte/half lane, then extend according to funct3.
    always_comb begin
        case (lane_i)
            2'd0:    byte_s = rdata_i[7:0];
            2'd1:    byte_s = rdata_i[15:8];
            2'd2:    byte_s = rdata_i[23:16];
            2'd3:    byte_s = rdata_i[31:24];
            default: byte_s = rdata_i[7:0];
        endcase
        if (lane_i[1]) begin
            half_s = rdata_i[31:16];
        end else begin
            half_s = rdata_i[15:0];
        end
        case (funct3_i)
            F3_B:    rdata_ext_o = {{24{byte_s[7]}}, byte_s};
            F3_BU:   rdata_ext_o = {24'h00_0000, byte_s};
            F3_H:    rdata_ext_o = {{16{half_s[15]}}, half_s};
            F3_HU:   rdata_ext_o = {16'h0000, half_s};
            default: rdata_ext_o = rdata_i;
        endcase
    end

    // Store merge: overwrite only the addressed lane(s) of the old word.
    always_comb begin
        merged_o = rdata_i;
        if (f3_is_byte(funct3_i)) begin
            case (lane_i)
                2'd0:    merged_o[7:0]   = wdata_i[7:0];
                2'd1:    merged_o[15:8]  = wdata_i[7:0];
                2'd2:    merged_o[23:16] = wdata_i[7:0];
                2'd3:    merged_o[31:24] = wdata_i[7:0];
                default: merged_o[7:0]   = wdata_i[7:0];
            endcase
        end else if (f3_is_half(funct3_i)) begin
            if (lane_i[1]) begin
                merged_o[31:16] = wdata_i[15:0];
            end else begin
                merged_o[15:0] = wdata_i[15:0];
            end
        end else begin
            merged_o = wdata_i;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: converts RV32I loads/stores into word accesses on a
// synchronous-read, word-write data memory. Sub-word stores use
// read-modify-write because the memory has no byte enables.
// Optional macro MISALIGN_TRAP_EN: misaligned H/HU/W accesses go to an ERR
// state and respond with resp_err=1 without touching memory. Without it the
// low address bits are forced to natural alignment and resp_err is 0.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_store, req_funct3         access kind and size
//   req_addr, req_wdata           byte address, store data
//   resp_valid/resp_rdata/resp_err one-cycle completion pulse and result
//   mem_ren/mem_wen/mem_addr/mem_wdata/mem_rdata  data memory interface
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    lsu_state_t            state_q, state_d;
    logic                  store_q, store_d;
    logic [2:0]            f3_q, f3_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  ready_q, ren_q, wen_q, rvalid_q;

    logic                  req_byte_s, req_half_s, req_word_s;
    logic                  misalign_s;
    logic [DATA_WIDTH-1:0] req_addr_aln_s;
    logic [DATA_WIDTH-1:0] rdata_ext_s, merged_s;

    assign req_byte_s = f3_is_byte(req_funct3);
    assign req_half_s = f3_is_half(req_funct3);
    assign req_word_s = !req_byte_s && !req_half_s;

`ifdef MISALIGN_TRAP_EN
    logic err_q;
    assign misalign_s     = (req_half_s && req_addr[0]) ||
                            (req_word_s && (req_addr[1:0] != 2'b00));
    assign req_addr_aln_s = req_addr;
    assign resp_err       = err_q;
`else
    // Force natural alignment so the access still lands on a legal lane.
    assign misalign_s     = 1'b0;
    assign req_addr_aln_s = {req_addr[DATA_WIDTH-1:2],
                             req_word_s ? 1'b0 : req_addr[1],
                             (req_word_s || req_half_s) ? 1'b0 : req_addr[0]};
    assign resp_err       = 1'b0;
`endif

    lsu_align u_align (
        .rdata_i     (mem_rdata),
        .wdata_i     (wdata_q),
        .lane_i      (addr_q[1:0]),
        .funct3_i    (f3_q),
        .rdata_ext_o (rdata_ext_s),
        .merged_o    (merged_s)
    );

    // Next-state and request-latch logic.
    always_comb begin
        state_d = state_q;
        store_d = store_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d = req_store;
                    f3_d    = req_funct3;
                    addr_d  = req_addr_aln_s;
                    wdata_d = req_wdata;
                    if (misalign_s) begin
                        state_d = ERR;
                    end else if (!req_store) begin
                        state_d = LD_RD;
                    end else if (req_word_s) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = RMW_RD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LD_RD:   state_d = LD_CAP;
            RMW_RD:  state_d = RMW_WR;
            LD_CAP,
            ST_WR,
            RMW_WR,
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request registers and registered strobes decoded from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            store_q  <= 1'b0;
            f3_q     <= 3'b000;
            addr_q   <= {DATA_WIDTH{1'b0}};
            wdata_q  <= {DATA_WIDTH{1'b0}};
            ready_q  <= 1'b1;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            f3_q     <= f3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ready_q  <= (state_d == IDLE);
            ren_q    <= (state_d == LD_RD) || (state_d == RMW_RD);
            wen_q    <= (state_d == ST_WR) || (state_d == RMW_WR);
            rvalid_q <= (state_d == LD_CAP) || (state_d == ST_WR) ||
                        (state_d == RMW_WR) || (state_d == ERR);
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Error flag register, high only while in ERR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_d == ERR);
        end
    end
`endif

    assign req_ready  = ready_q;
    assign mem_ren    = ren_q;
    assign mem_wen    = wen_q;
    assign resp_valid = rvalid_q;
    assign mem_addr   = {2'b00, addr_q[DATA_WIDTH-1:2]};

    // Read data only exists in LD_CAP; it arrives from memory that cycle.
    always_comb begin
        if ((state_q == LD_CAP) && !store_q) begin
            resp_rdata = rdata_ext_s;
        end else begin
            resp_rdata = {DATA_WIDTH{1'b0}};
        end
    end

    // Write data: raw word for SW, merged word in the RMW write cycle.
    always_comb begin
        case (state_q)
            ST_WR:   mem_wdata = wdata_q;
            RMW_WR:  mem_wdata = merged_s;
            default: mem_wdata = {DATA_WIDTH{1'b0}};
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit with a behavioural
// reference memory. Builds with or without MISALIGN_TRAP_EN.
module tb_load_store_unit;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    int n_checks = 0;
    int n_errors = 0;

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // data_mem: registered read, full-word write
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preset(input int idx, input logic [31:0] val);
        mem[idx] <= val;
        ref_mem[idx] = val;
    endtask

    // Reference model: expected outcome of one access from the ISA rules.
    task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd,
                         output logic [31:0] e_rdata, output bit e_err, output int e_lat,
                         output int e_ren, output int e_wen, output logic [31:0] e_wdata);
        int size, off, widx;
        bit uns, mis;
        longint unsigned word, v, lim, mask, nw;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        uns  = (f3 == 3'b100) || (f3 == 3'b101);
        off  = int'(a % 4);
        mis  = (off % size) != 0;
        e_err = TRAP && mis;
        if (!TRAP) off = off - (off % size);
        widx = int'((a / 4) % 256);
        word = longint'(ref_mem[widx]);
        lim  = 64'd1 << (8 * size);
        e_rdata = 32'h0;
        e_wdata = 32'h0;
        if (e_err) begin
            e_lat = 1; e_ren = 0; e_wen = 0;
        end else if (!st) begin
            v = (word >> (8 * off)) % lim;
            if (!uns && size < 4 && v >= lim / 2) v = v + (64'h1_0000_0000 - lim);
            e_rdata = v[31:0];
            e_lat = 2; e_ren = 1; e_wen = 0;
        end else begin
            if (size == 4) begin
                nw = longint'(wd);
            end else begin
                mask = (lim - 1) << (8 * off);
                nw = (word & ~mask) | ((longint'(wd) % lim) << (8 * off));
            end
            e_wdata = nw[31:0];
            ref_mem[widx] = nw[31:0];
            e_lat = (size == 4) ? 1 : 2;
            e_ren = (size == 4) ? 0 : 1;
            e_wen = 1;
        end
    endtask

    // One access; called and returns at a negedge.
    task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input string tag,
                             output logic [31:0] got_rdata, output logic got_err);
        logic [31:0] e_rdata, e_wdata, got_wdata;
        bit e_err;
        int e_lat, e_ren, e_wen, lat, ren_cnt, wen_cnt, ren_first, wen_k;
        model(st, f3, a, wd, e_rdata, e_err, e_lat, e_ren, e_wen, e_wdata);
        check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0; ren_cnt = 0; wen_cnt = 0; ren_first = 0; wen_k = 0;
        got_wdata = 32'h0; got_rdata = 32'h0; got_err = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            check({tag, "_excl"}, {31'b0, mem_ren & mem_wen}, 32'd0);
            check({tag, "_addr"}, mem_addr, a >> 2);
            if (mem_ren) begin
                ren_cnt++;
                if (ren_first == 0) ren_first = k;
            end
            if (mem_wen) begin
                wen_cnt++; wen_k = k; got_wdata = mem_wdata;
            end
            if (resp_valid) begin
                lat = k; got_rdata = resp_rdata; got_err = resp_err;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        check({tag, "_lat"}, lat, e_lat);
        check({tag, "_rdata"}, got_rdata, e_rdata);
        check({tag, "_err"}, {31'b0, got_err}, {31'b0, e_err});
        check({tag, "_ren_cnt"}, ren_cnt, e_ren);
        check({tag, "_wen_cnt"}, wen_cnt, e_wen);
        if (e_ren != 0) check({tag, "_ren_cyc"}, ren_first, 1);
        if (e_wen != 0) begin
            check({tag, "_wdata"}, got_wdata, e_wdata);
            check({tag, "_wen_cyc"}, wen_k, e_lat);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  {31'b0, req_ready},  32'd1);
        check({tag, "_rvalid"}, {31'b0, resp_valid}, 32'd0);
        check({tag, "_err"},    {31'b0, resp_err},   32'd0);
        check({tag, "_ren"},    {31'b0, mem_ren},    32'd0);
        check({tag, "_wen"},    {31'b0, mem_wen},    32'd0);
        check({tag, "_rdata"},  resp_rdata,          32'd0);
        check({tag, "_maddr"},  mem_addr,            32'd0);
        check({tag, "_mwdata"}, mem_wdata,           32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        logic [2:0]  f3_tab [5];
        f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
        f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;

        for (int i = 0; i < 256; i++) preset(i, $urandom);
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1/2: word 7 lane extraction
        preset(7, 32'h8081_82F3);
        #1;
        @(negedge clk);
        do_access(1'b0, 3'b000, 32'h1C, 32'h0, "lb_1c", r, e);  check("lb_1c_const", r, 32'hFFFF_FFF3);
        do_access(1'b0, 3'b100, 32'h1F, 32'h0, "lbu_1f", r, e); check("lbu_1f_const", r, 32'h0000_0080);
        do_access(1'b0, 3'b001, 32'h1E, 32'h0, "lh_1e", r, e);  check("lh_1e_const", r, 32'hFFFF_8081);
        do_access(1'b0, 3'b101, 32'h1C, 32'h0, "lhu_1c", r, e); check("lhu_1c_const", r, 32'h0000_82F3);
        do_access(1'b0, 3'b010, 32'h1C, 32'h0, "lw_1c", r, e);  check("lw_1c_const", r, 32'h8081_82F3);

        // 3: SB read-modify-write then LW
        preset(4, 32'h1122_3344);
        #1;
        @(negedge clk);
        do_access(1'b1, 3'b000, 32'h12, 32'h0000_00AB, "sb_12", r, e);
        do_access(1'b0, 3'b010, 32'h10, 32'h0, "lw_10", r, e);  check("lw_10_const", r, 32'h11AB_3344);

        // 4: SW single write cycle
        do_access(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, "sw_40", r, e);
        check("sw_40_mem", mem[16], 32'hDEAD_BEEF);

        // 5: misaligned LH
        preset(8, 32'h1234_ABCD);
        #1;
        @(negedge clk);
        do_access(1'b0, 3'b001, 32'h21, 32'h0, "lh_21", r, e);
        check("lh_21_const", r, TRAP ? 32'h0 : 32'hFFFF_ABCD);
        check("lh_21_err", {31'b0, e}, {31'b0, TRAP});

        // 6: reset during RMW_RD of an SB
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h12; req_wdata = 32'h0000_0055;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid_rmw_rd", {31'b0, mem_ren}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_mid_nowen", {31'b0, mem_wen}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_rel");
        check("rst_word4", mem[4], ref_mem[4]);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [2:0] f3;
            bit st;
            f3 = f3_tab[$urandom_range(0, 4)];
            st = ($urandom_range(0, 1) == 1) && !f3[2];
            do_access(st, f3, $urandom_range(0, 1023), $urandom, "rnd", r, e);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        for (int i = 0; i < 256; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
